// File: rtl/reg_file_pkg.sv
// Shared widths and types for the register file, control unit and ALU wrapper.
// The ALU operand width must match DATA_W.
package reg_file_pkg;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/reg_file_if.sv
// Write-back and dual read bus between the control/ALU side and the register file.
// Purely combinational signals; there is no handshake and no backpressure.
interface reg_file_if;
  import reg_file_pkg::*;

  reg_data_t in_dat;
  reg_addr_t in_address;
  logic      write;
  reg_addr_t out1_address;
  reg_addr_t out2_address;
  reg_data_t out1_dat;
  reg_data_t out2_dat;
  logic      out1_valid;
  logic      out2_valid;

  modport master (
    output in_dat, in_address, write, out1_address, out2_address,
    input  out1_dat, out2_dat, out1_valid, out2_valid
  );

  modport slave (
    input  in_dat, in_address, write, out1_address, out2_address,
    output out1_dat, out2_dat, out1_valid, out2_valid
  );
endinterface

// File: rtl/reg_file_read_port.sv
// One read port: address mux over the storage array plus optional write forwarding.
// Latency: zero cycles (combinational); no backpressure.
module reg_read_port
  import reg_file_pkg::*;
#(
  parameter bit BYPASS = 1'b0
) (
  input  reg_data_t           mem [NUM_REGS],
  input  logic [NUM_REGS-1:0] valid,
  input  logic                wr_en,
  input  reg_addr_t           wr_addr,
  input  reg_data_t           wr_dat,
  input  reg_addr_t           rd_addr,
  output reg_data_t           rd_dat,
  output logic                rd_valid
);
  always_comb begin
    rd_dat   = mem[rd_addr];
    rd_valid = valid[rd_addr];
    // wr_en already excludes reset, so a discarded write is never forwarded
    if (BYPASS && wr_en && (wr_addr == rd_addr)) begin
      rd_dat   = wr_dat;
      rd_valid = 1'b1;
    end
  end
endmodule

// File: rtl/reg_file.sv
// 8x8 register file with one write-back port and two combinational ALU operand ports.
// Latency: reads zero-cycle, writes visible after the edge; no backpressure.
module reg_file
  import reg_file_pkg::*;
#(
  parameter bit BYPASS = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  reg_file_if.slave  rf
);
  reg_data_t           mem [NUM_REGS];
  logic [NUM_REGS-1:0] valid;
  logic                wr_en;

  assign wr_en = rf.write && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
      valid <= '0;
    end else if (rf.write) begin
      mem[rf.in_address]   <= rf.in_dat;
      valid[rf.in_address] <= 1'b1;
    end
  end

  reg_read_port #(.BYPASS(BYPASS)) u_port1 (
    .mem      (mem),
    .valid    (valid),
    .wr_en    (wr_en),
    .wr_addr  (rf.in_address),
    .wr_dat   (rf.in_dat),
    .rd_addr  (rf.out1_address),
    .rd_dat   (rf.out1_dat),
    .rd_valid (rf.out1_valid)
  );

  reg_read_port #(.BYPASS(BYPASS)) u_port2 (
    .mem      (mem),
    .valid    (valid),
    .wr_en    (wr_en),
    .wr_addr  (rf.in_address),
    .wr_dat   (rf.in_dat),
    .rd_addr  (rf.out2_address),
    .rd_dat   (rf.out2_dat),
    .rd_valid (rf.out2_valid)
  );
endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: one instance without forwarding, one with, driven identically
// and compared every cycle against an array model of the register contents.
module tb_reg_file;
  import reg_file_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic      wr;
  reg_data_t wdat;
  reg_addr_t waddr, a1, a2;

  reg_file_if if0 ();
  reg_file_if if1 ();

  assign if0.write = wr;        assign if1.write = wr;
  assign if0.in_dat = wdat;     assign if1.in_dat = wdat;
  assign if0.in_address = waddr; assign if1.in_address = waddr;
  assign if0.out1_address = a1; assign if1.out1_address = a1;
  assign if0.out2_address = a2; assign if1.out2_address = a2;

  reg_file #(.BYPASS(1'b0)) dut0 (.clk(clk), .reset(reset), .rf(if0));
  reg_file #(.BYPASS(1'b1)) dut1 (.clk(clk), .reset(reset), .rf(if1));

  int vectors    = 0;
  int miscompares = 0;
  bit chk_en     = 1'b0;

  // Reference: plain array of register values and written-since-reset flags
  int model_val [8];
  bit model_wr  [8];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        model_val[i] = 0;
        model_wr[i]  = 1'b0;
      end
    end else if (wr) begin
      model_val[waddr] = int'(wdat);
      model_wr[waddr]  = 1'b1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_dat(input bit byp, input int addr);
    if (byp && wr && !reset && int'(waddr) == addr) return int'(wdat);
    return model_val[addr];
  endfunction

  function automatic int exp_vld(input bit byp, input int addr);
    if (byp && wr && !reset && int'(waddr) == addr) return 1;
    return int'(model_wr[addr]);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("dut0.out1", int'(if0.out1_dat), exp_dat(1'b0, int'(a1)));
      check("dut0.v1",   int'(if0.out1_valid), exp_vld(1'b0, int'(a1)));
      check("dut0.out2", int'(if0.out2_dat), exp_dat(1'b0, int'(a2)));
      check("dut0.v2",   int'(if0.out2_valid), exp_vld(1'b0, int'(a2)));
      check("dut1.out1", int'(if1.out1_dat), exp_dat(1'b1, int'(a1)));
      check("dut1.v1",   int'(if1.out1_valid), exp_vld(1'b1, int'(a1)));
      check("dut1.out2", int'(if1.out2_dat), exp_dat(1'b1, int'(a2)));
      check("dut1.v2",   int'(if1.out2_valid), exp_vld(1'b1, int'(a2)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1; wr = 1'b0; wdat = '0; waddr = '0; a1 = '0; a2 = '0;
    tick();
    reset = 1'b0;
    chk_en = 1'b1;

    // Reset state on every index, both ports
    for (int i = 0; i < 8; i++) begin
      a1 = reg_addr_t'(i); a2 = reg_addr_t'(7 - i);
      #1;
      check("rst.out1", int'(if0.out1_dat), 8'h00);
      check("rst.out2", int'(if0.out2_dat), 8'h00);
      check("rst.v1",   int'(if0.out1_valid), 0);
      check("rst.v2",   int'(if1.out2_valid), 0);
      tick();
    end

    // Single write then read on both ports
    wr = 1'b1; waddr = 3'd3; wdat = 8'h2A;
    tick();
    wr = 1'b0; a1 = 3'd3; a2 = 3'd3;
    #1;
    check("wr.out1", int'(if0.out1_dat), 8'h2A);
    check("wr.out2", int'(if0.out2_dat), 8'h2A);
    check("wr.v1",   int'(if0.out1_valid), 1);
    check("wr.v2",   int'(if0.out2_valid), 1);
    a2 = 3'd4;
    #1;
    check("wr.other", int'(if0.out2_dat), 8'h00);
    check("wr.otherv", int'(if0.out2_valid), 0);
    tick();

    // WRITE=0 must not disturb the array
    wr = 1'b0; waddr = 3'd3; wdat = 8'hFF;
    tick();
    #1;
    check("nowr.out1", int'(if0.out1_dat), 8'h2A);
    check("nowr.out1b", int'(if1.out1_dat), 8'h2A);

    // Reset wins over a simultaneous write
    reset = 1'b1; wr = 1'b1; waddr = 3'd5; wdat = 8'h77;
    tick();
    reset = 1'b0; wr = 1'b0; a1 = 3'd5; a2 = 3'd3;
    #1;
    check("coll.r5", int'(if0.out1_dat), 8'h00);
    check("coll.v5", int'(if0.out1_valid), 0);
    check("coll.r3", int'(if0.out2_dat), 8'h00);
    check("coll.r5b", int'(if1.out1_dat), 8'h00);

    // Forwarding: dut1 shows new data before the edge, dut0 after
    wr = 1'b1; waddr = 3'd2; wdat = 8'h05;
    tick();
    wr = 1'b1; waddr = 3'd2; wdat = 8'h11; a2 = 3'd2;
    #1;
    check("byp.on",   int'(if1.out2_dat), 8'h11);
    check("byp.onv",  int'(if1.out2_valid), 1);
    check("byp.off",  int'(if0.out2_dat), 8'h05);
    tick();
    wr = 1'b0;
    #1;
    check("byp.after", int'(if0.out2_dat), 8'h11);

    // Full sweep
    for (int i = 0; i < 8; i++) begin
      wr = 1'b1; waddr = reg_addr_t'(i); wdat = reg_data_t'(8'h10 + i);
      tick();
    end
    wr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a1 = reg_addr_t'(i); a2 = reg_addr_t'(7 - i);
      #1;
      check("sweep.out1", int'(if0.out1_dat), 8'h10 + i);
      check("sweep.out2", int'(if1.out2_dat), 8'h10 + 7 - i);
      check("sweep.v1",   int'(if0.out1_valid), 1);
      check("sweep.v2",   int'(if1.out2_valid), 1);
      tick();
    end

    // Randomized traffic with frequent address coincidences and rare resets
    for (int n = 0; n < 2000; n++) begin
      reset = ($urandom_range(0, 31) == 0);
      wr    = 1'($urandom_range(0, 1));
      waddr = reg_addr_t'($urandom_range(0, 7));
      wdat  = reg_data_t'($urandom_range(0, 255));
      a1    = ($urandom_range(0, 3) == 0) ? waddr : reg_addr_t'($urandom_range(0, 7));
      a2    = ($urandom_range(0, 3) == 0) ? a1    : reg_addr_t'($urandom_range(0, 7));
      tick();
    end

    chk_en = 1'b0;
    reset = 1'b0; wr = 1'b0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
